serial_pair_tx: RTL

SERIAL_PAIR_TX -- requirements
Module: serial_pair_tx

---
 rtl/serial_pair_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_pair_tx.sv
// Dual-lane serialiser: captures a pair of WIDTH-bit words and shifts them out
// on two serial lanes. Each frame is bracketed by a frame_clr pulse and a done pulse.
module serial_pair_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             in_ready,
  output logic             serial_a,
  output logic             serial_b,
  output logic             frame_clr,
  output logic             bit_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] count, next_count;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [WIDTH-1:0] sh_a_next, sh_b_next;
  logic             head_a, head_b;
  logic             accept;

  assign in_ready = (state == IDLE) || (state == DONE);
  assign accept   = in_valid && in_ready;

  // The outgoing bit is always the head of the shift register; its end depends on bit order.
  assign head_a    = MSB_FIRST ? sh_a[WIDTH-1] : sh_a[0];
  assign head_b    = MSB_FIRST ? sh_b[WIDTH-1] : sh_b[0];
  assign sh_a_next = MSB_FIRST ? {sh_a[WIDTH-2:0], 1'b0} : {1'b0, sh_a[WIDTH-1:1]};
  assign sh_b_next = MSB_FIRST ? {sh_b[WIDTH-2:0], 1'b0} : {1'b0, sh_b[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      IDLE: begin
        if (accept) next_state = START;
      end
      START: begin
        next_state = SHIFT;
        next_count = '0;
      end
      SHIFT: begin
        if (count == LAST_BIT) next_state = DONE;
        else                   next_count = count + CNT_W'(1);
      end
      DONE: begin
        next_state = accept ? START : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      serial_a  <= 1'b0;
      serial_b  <= 1'b0;
      frame_clr <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      count     <= next_count;
      frame_clr <= (next_state == START);
      bit_valid <= (next_state == SHIFT);
      done      <= (next_state == DONE);
      if (accept) begin
        sh_a     <= in_a;
        sh_b     <= in_b;
        serial_a <= 1'b0;
        serial_b <= 1'b0;
      end else if (next_state == SHIFT) begin
        serial_a <= head_a;
        serial_b <= head_b;
        sh_a     <= sh_a_next;
        sh_b     <= sh_b_next;
      end else begin
        serial_a <= 1'b0;
        serial_b <= 1'b0;
      end
    end
  end

endmodule
